// File: rtl/cardinal_nic_ctrl_if.sv
// PE-side and NIC-side handshake/bus signals of the cardinal_nic controller.
// The controller uses the slave modport; the environment driving it uses master.
interface cardinal_nic_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic [1:0]        nic_addr;
  logic              nic_en;
  logic              nic_en_wr;
  logic [DATA_W-1:0] nic_wdata;
  logic [DATA_W-1:0] nic_rdata;

  modport slave (
    input  tx_valid, tx_data, rx_ready, nic_rdata,
    output tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_en_wr, nic_wdata
  );

  modport master (
    output tx_valid, tx_data, rx_ready, nic_rdata,
    input  tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_en_wr, nic_wdata
  );
endinterface

// File: rtl/cardinal_nic_ctrl.sv
// Drives the cardinal_nic CPU port for a PE: buffers TX packets in a small FIFO,
// polls NIC status, writes/reads the NIC buffers, round-robins TX and RX service.
module cardinal_nic_ctrl #(
  parameter int DATA_W   = 64,
  parameter int TX_DEPTH = 4,
  parameter int RD_LAT   = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  cardinal_nic_ctrl_if.slave bus,
  output logic [CNT_W-1:0]  tx_sent,
  output logic [CNT_W-1:0]  rx_recv
);
  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    IDLE, POLL_TX, WAIT_TX, WRITE_TX, POLL_RX, WAIT_RX, READ_RX, WAIT_RD
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [TX_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop, tx_pend, rx_pend, last_tx, capture, status_bit;

  assign status_bit   = bus.nic_rdata[0];
  assign bus.tx_ready = !reset && (count != DEPTH_C);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign pop          = (state == WRITE_TX);
  assign tx_pend      = (count != '0);
  assign rx_pend      = !bus.rx_valid;

  // TX FIFO: registered head, no fall-through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // Control: sequencer state, arbitration history, RX holding register, counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_tx     <= 1'b0;
      tx_sent     <= '0;
      rx_recv     <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == POLL_TX) last_tx <= 1'b1;
      if (state == IDLE && state_nxt == POLL_RX) last_tx <= 1'b0;
      if (pop) tx_sent <= tx_sent + 1'b1;
      if (capture) begin
        bus.rx_data  <= bus.nic_rdata;
        bus.rx_valid <= 1'b1;
        rx_recv      <= rx_recv + 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

  // Next state and NIC strobes, all decoded from the current state
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    bus.nic_en    = 1'b0;
    bus.nic_en_wr = 1'b0;
    bus.nic_addr  = 2'b00;
    bus.nic_wdata = '0;
    case (state)
      IDLE: begin
        if (tx_pend && rx_pend) state_nxt = last_tx ? POLL_RX : POLL_TX;
        else if (tx_pend)       state_nxt = POLL_TX;
        else if (rx_pend)       state_nxt = POLL_RX;
      end
      POLL_TX: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = 2'b11;
        if (RD_LAT != 0) state_nxt = WAIT_TX;
        else             state_nxt = status_bit ? IDLE : WRITE_TX;
      end
      WAIT_TX: begin
        bus.nic_addr = 2'b11;
        state_nxt    = status_bit ? IDLE : WRITE_TX;
      end
      WRITE_TX: begin
        bus.nic_en    = 1'b1;
        bus.nic_en_wr = 1'b1;
        bus.nic_addr  = 2'b10;
        bus.nic_wdata = mem[rd_ptr];
        state_nxt     = IDLE;
      end
      POLL_RX: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = 2'b01;
        if (RD_LAT != 0) state_nxt = WAIT_RX;
        else             state_nxt = status_bit ? READ_RX : IDLE;
      end
      WAIT_RX: begin
        bus.nic_addr = 2'b01;
        state_nxt    = status_bit ? READ_RX : IDLE;
      end
      READ_RX: begin
        bus.nic_en = 1'b1;
        if (RD_LAT != 0) begin
          state_nxt = WAIT_RD;
        end else begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RD: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cardinal_nic_ctrl.sv
// Directed bench for cardinal_nic_ctrl: one instance per NIC read latency, each with
// a small behavioural NIC; the unused instance is held in reset.
module tb_cardinal_nic_ctrl;
  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        sel = 1'b0;
  logic        tx_valid = 1'b0, rx_ready = 1'b0;
  logic [63:0] tx_data = '0;
  logic        st11 = 1'b1, st01 = 1'b0;
  logic [63:0] rxbuf = '0;
  logic [15:0] sent0, recv0, sent1, recv1;
  int          n_tests = 0, n_fail = 0;
  int          exp_sent, exp_recv;
  logic [63:0] wq [$];
  logic [1:0]  pq [$];

  always #5 clk = ~clk;

  cardinal_nic_ctrl_if #(.DATA_W(64)) b0 ();
  cardinal_nic_ctrl_if #(.DATA_W(64)) b1 ();

  assign b0.tx_valid = tx_valid;
  assign b0.tx_data  = tx_data;
  assign b0.rx_ready = rx_ready;
  assign b1.tx_valid = tx_valid;
  assign b1.tx_data  = tx_data;
  assign b1.rx_ready = rx_ready;

  cardinal_nic_ctrl #(.DATA_W(64), .TX_DEPTH(4), .RD_LAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(b0), .tx_sent(sent0), .rx_recv(recv0));
  cardinal_nic_ctrl #(.DATA_W(64), .TX_DEPTH(4), .RD_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(b1), .tx_sent(sent1), .rx_recv(recv1));

  // NIC model: combinational read for latency 0, registered read for latency 1
  always_comb begin
    b0.nic_rdata = '0;
    case (b0.nic_addr)
      2'b11:   b0.nic_rdata = {63'd0, st11};
      2'b01:   b0.nic_rdata = {63'd0, st01};
      2'b00:   b0.nic_rdata = rxbuf;
      default: b0.nic_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    case (b1.nic_addr)
      2'b11:   b1.nic_rdata <= {63'd0, st11};
      2'b01:   b1.nic_rdata <= {63'd0, st01};
      2'b00:   b1.nic_rdata <= rxbuf;
      default: b1.nic_rdata <= '0;
    endcase
  end

  wire        o_en     = sel ? b1.nic_en    : b0.nic_en;
  wire        o_wr     = sel ? b1.nic_en_wr : b0.nic_en_wr;
  wire [1:0]  o_addr   = sel ? b1.nic_addr  : b0.nic_addr;
  wire [63:0] o_wdata  = sel ? b1.nic_wdata : b0.nic_wdata;
  wire        o_txr    = sel ? b1.tx_ready  : b0.tx_ready;
  wire        o_rxv    = sel ? b1.rx_valid  : b0.rx_valid;
  wire [63:0] o_rxd    = sel ? b1.rx_data   : b0.rx_data;
  wire [15:0] o_sent   = sel ? sent1 : sent0;
  wire [15:0] o_recv   = sel ? recv1 : recv0;

  always @(negedge clk) begin
    if (o_en && o_wr)  wq.push_back(o_wdata);
    if (o_en && !o_wr) pq.push_back(o_addr);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_addr(input logic [1:0] a);
    int n = 0;
    foreach (pq[i]) if (pq[i] == a) n++;
    return n;
  endfunction

  task automatic push(input logic [63:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_rxv(input string tag, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (o_rxv) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_wr(input string tag, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (o_en && o_wr) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input logic s);
    sel = s; rst0 = 1'b1; rst1 = 1'b1;
    tx_valid = 1'b0; rx_ready = 1'b0; st11 = 1'b1; st01 = 1'b0; rxbuf = '0;
    exp_sent = 0; exp_recv = 0;
    tick(); tick();
    chk("rst_tx_ready", o_txr, 0);
    chk("rst_en", o_en, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_rx_valid", o_rxv, 0);
    chk("rst_rx_data", o_rxd, 0);
    chk("rst_tx_sent", o_sent, 0);
    chk("rst_rx_recv", o_recv, 0);
    if (s) rst1 = 1'b0; else rst0 = 1'b0;
    tick();
    chk("rel_tx_ready", o_txr, 1);
    wq.delete(); pq.delete();
  endtask

  // Capture one packet and hold it: polling of addr 01 must stop.
  task automatic t3_capture();
    st01 = 1'b1; rxbuf = 64'd1738; rx_ready = 1'b0;
    wait_rxv("t3_rxv", 20);
    exp_recv++;
    chk("t3_rx_data", o_rxd, 64'd1738);
    chk("t3_rx_recv", o_recv, exp_recv);
    pq.delete();
    repeat (10) tick();
    chk("t3_no_poll01", cnt_addr(2'b01), 0);
    chk("t3_rx_recv_hold", o_recv, exp_recv);
    chk("t3_rx_data_hold", o_rxd, 64'd1738);
  endtask

  task automatic t3_release();
    st01 = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("t3_rx_valid_clr", o_rxv, 0);
    pq.delete();
    repeat (10) tick();
    chk("t3_poll_resume", cnt_addr(2'b01) > 0, 1);
  endtask

  task automatic t1(input int lat);
    st11 = 1'b0;
    wq.delete();
    push(64'd1234);
    tick();
    chk("t1_poll_en", o_en, 1);
    chk("t1_poll_wr", o_wr, 0);
    chk("t1_poll_addr", o_addr, 2'b11);
    if (lat != 0) begin
      tick();
      chk("t1_wait_en", o_en, 0);
    end
    tick();
    chk("t1_wr_en", o_en, 1);
    chk("t1_wr_wr", o_wr, 1);
    chk("t1_wr_addr", o_addr, 2'b10);
    chk("t1_wr_data", o_wdata, 64'd1234);
    tick();
    exp_sent++;
    chk("t1_tx_sent", o_sent, exp_sent);
    chk("t1_idle_en", o_en, 0);
  endtask

  task automatic t2();
    bit ok = 0;
    st11 = 1'b1;
    push(64'd55);
    wq.delete(); pq.delete();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cnt_addr(2'b11) >= 3) begin ok = 1; break; end
    end
    if (!ok) chk("t2_polls_timeout", 0, 1);
    st11 = 1'b0;
    chk("t2_no_write_busy", wq.size(), 0);
    chk("t2_sent_busy", o_sent, exp_sent);
    wait_wr("t2_wr", 20);
    repeat (10) tick();
    exp_sent++;
    chk("t2_write_count", wq.size(), 1);
    if (wq.size() > 0) chk("t2_write_data", wq[0], 64'd55);
    chk("t2_poll_count", cnt_addr(2'b11), 4);
    chk("t2_tx_sent", o_sent, exp_sent);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- latency-0 instance ----
    do_reset(1'b0);
    t3_capture();
    t1(0);
    t2();
    t3_release();

    // T4: TX and RX both pending, TX status busy: polls alternate
    st11 = 1'b1; st01 = 1'b0;
    push({1'b1, 63'd4});
    pq.delete();
    for (int i = 0; i < 80 && pq.size() < 8; i++) tick();
    chk("t4_poll_count", pq.size() >= 8, 1);
    begin
      int rep = 0;
      for (int i = 1; i < pq.size(); i++) if (pq[i] == pq[i-1]) rep++;
      chk("t4_alternate", rep, 0);
    end
    wq.delete();
    st11 = 1'b0;
    wait_wr("t4_wr", 20);
    tick();
    exp_sent++;
    if (wq.size() > 0) chk("t4_write_data", wq[0], {1'b1, 63'd4});
    else chk("t4_write_seen", 0, 1);
    st01 = 1'b1; rxbuf = 64'd99;
    wait_rxv("t4_rxv", 20);
    st01 = 1'b0;
    exp_recv++;
    chk("t4_rx_data", o_rxd, 64'd99);
    chk("t4_rx_recv", o_recv, exp_recv);

    // T5: fill the FIFO while TX status is busy
    st11 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data  = 64'(10 + i);
      tx_valid = 1'b1;
      tick();
      chk($sformatf("t5_ready_%0d", i), o_txr, (i + 1 < 4) ? 1 : 0);
    end
    tx_valid = 1'b0;
    wq.delete();
    st11 = 1'b0;
    for (int i = 0; i < 60 && wq.size() < 4; i++) tick();
    repeat (20) tick();
    exp_sent += 4;
    chk("t5_write_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      chk($sformatf("t5_write_%0d", i), wq[i], 64'(10 + i));
    chk("t5_tx_sent", o_sent, exp_sent);
    chk("t5_tx_ready", o_txr, 1);

    // T6: reset asserted in the middle of a NIC write
    push(64'd77);
    push(64'd78);
    wait_wr("t6_wr", 20);
    rst0 = 1'b1;
    #1;
    chk("t6_en", o_en, 0);
    chk("t6_wr", o_wr, 0);
    chk("t6_tx_ready", o_txr, 0);
    chk("t6_tx_sent", o_sent, 0);
    chk("t6_rx_recv", o_recv, 0);
    chk("t6_rx_valid", o_rxv, 0);
    tick();
    rst0 = 1'b0;
    tick();
    wq.delete();
    repeat (20) tick();
    chk("t6_fifo_empty", wq.size(), 0);
    chk("t6_sent_after", o_sent, 0);

    // ---- latency-1 instance ----
    do_reset(1'b1);
    t3_capture();
    t1(1);
    t2();
    t3_release();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
